// File: rtl/cb_heep_boot_seq.sv
// -----------------------------------------------------------------------------
// cb_heep_boot_seq
//
// Boot-release sequencer for the multi-core CB-heep cluster. Cores spin in a
// boot wait loop until their exit-loop line is raised. On an accepted start
// this block walks the latched core mask in ascending index order. For every
// selected core it pulses that core's exit-loop line, then waits for the core
// to acknowledge. If a non-zero timeout is programmed and the core stays
// silent, the sequence stops with a sticky error. Any remaining cores are
// left parked in that case.
//
// Ports
//   clk_i        clock
//   rst_ni       asynchronous, active-low reset
//   start_i      single-cycle start request, ignored while busy_o=1
//   core_mask_i  cores to release, sampled on an accepted start
//   timeout_i    max WAIT_ACK cycles per core (0 = no timeout), sampled on start
//   core_ack_i   per-core level ack, high once the core has left its boot loop
//   exit_loop_o  exit-loop pulse, at most one bit high at a time
//   busy_o       high in every state except IDLE
//   done_o       one-cycle pulse at the end of a sequence (success or error)
//   error_o      sticky timeout flag, cleared by the next accepted start
//   err_core_o   index of the core that timed out, valid while error_o=1
//
// State      | meaning
// -----------+----------------------------------------------------------------
// S_IDLE     | waiting for start_i
// S_SELECT   | examine mask[idx]: skip the core, pulse it, or finish at NCores
// S_PULSE    | exit_loop_o[idx] high for ExitPulseCycles cycles
// S_WAIT_ACK | wait for core_ack_i[idx], bounded by the programmed timeout
// S_DONE     | one-cycle done_o, back to idle
// S_ERROR    | one-cycle done_o with error_o/err_core_o set, back to idle
// -----------------------------------------------------------------------------
module cb_heep_boot_seq #(
    parameter int unsigned NCores          = 3,
    parameter int unsigned TimeoutW        = 16,
    parameter int unsigned ExitPulseCycles = 4,
    localparam int unsigned ErrW = (NCores > 1) ? $clog2(NCores) : 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                start_i,
    input  logic [NCores-1:0]   core_mask_i,
    input  logic [TimeoutW-1:0] timeout_i,
    input  logic [NCores-1:0]   core_ack_i,
    output logic [NCores-1:0]   exit_loop_o,
    output logic                busy_o,
    output logic                done_o,
    output logic                error_o,
    output logic [ErrW-1:0]     err_core_o
);

    // idx must be able to hold NCores itself: that value is the end marker.
    localparam int unsigned IdxW = $clog2(NCores + 1);
    localparam int unsigned PcW  = $clog2(ExitPulseCycles + 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SELECT   = 3'd1,
        S_PULSE    = 3'd2,
        S_WAIT_ACK = 3'd3,
        S_DONE     = 3'd4,
        S_ERROR    = 3'd5
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [IdxW-1:0]     r_idx;
    logic [IdxW-1:0]     w_idx_nxt;
    logic [PcW-1:0]      r_pcnt;
    logic [PcW-1:0]      w_pcnt_nxt;
    logic [TimeoutW-1:0] r_timer;
    logic [TimeoutW-1:0] w_timer_nxt;
    logic [NCores-1:0]   r_mask;
    logic [NCores-1:0]   w_mask_nxt;
    logic [TimeoutW-1:0] r_timeout;
    logic [TimeoutW-1:0] w_timeout_nxt;
    logic                r_error;
    logic                w_error_nxt;
    logic [ErrW-1:0]     r_err_core;
    logic [ErrW-1:0]     w_err_core_nxt;

    logic                w_sel_mask;
    logic                w_sel_ack;
    logic                w_timeout_hit;

    // Per-index selection of mask and ack. Written as a compare loop so that
    // idx == NCores (the end marker) never indexes past the vectors.
    always_comb begin
        w_sel_mask = 1'b0;
        w_sel_ack  = 1'b0;
        for (int i = 0; i < int'(NCores); i++) begin
            if (r_idx == IdxW'(i)) begin
                w_sel_mask = r_mask[i];
                w_sel_ack  = core_ack_i[i];
            end
        end
    end

    // Expires on the timeout-th WAIT_ACK cycle. The timer starts at 0 there.
    assign w_timeout_hit = (r_timeout != '0) &&
                           (r_timer == (r_timeout - TimeoutW'(1)));

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_idx      <= '0;
            r_pcnt     <= '0;
            r_timer    <= '0;
            r_mask     <= '0;
            r_timeout  <= '0;
            r_error    <= 1'b0;
            r_err_core <= '0;
        end else begin
            r_idx      <= w_idx_nxt;
            r_pcnt     <= w_pcnt_nxt;
            r_timer    <= w_timer_nxt;
            r_mask     <= w_mask_nxt;
            r_timeout  <= w_timeout_nxt;
            r_error    <= w_error_nxt;
            r_err_core <= w_err_core_nxt;
        end
    end

    // Next-state and datapath update
    always_comb begin
        w_state_nxt    = r_state;
        w_idx_nxt      = r_idx;
        w_pcnt_nxt     = r_pcnt;
        w_timer_nxt    = r_timer;
        w_mask_nxt     = r_mask;
        w_timeout_nxt  = r_timeout;
        w_error_nxt    = r_error;
        w_err_core_nxt = r_err_core;

        unique case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_mask_nxt     = core_mask_i;
                    w_timeout_nxt  = timeout_i;
                    w_idx_nxt      = '0;
                    w_error_nxt    = 1'b0;
                    w_err_core_nxt = '0;
                    w_state_nxt    = S_SELECT;
                end
            end

            S_SELECT: begin
                if (r_idx == IdxW'(NCores)) begin
                    w_state_nxt = S_DONE;
                end else if (w_sel_mask) begin
                    w_pcnt_nxt  = '0;
                    w_timer_nxt = '0;
                    w_state_nxt = S_PULSE;
                end else begin
                    w_idx_nxt = r_idx + IdxW'(1);
                end
            end

            // The pulse length is fixed. An early ack is seen only in WAIT_ACK.
            S_PULSE: begin
                if (r_pcnt == PcW'(ExitPulseCycles - 1)) begin
                    w_state_nxt = S_WAIT_ACK;
                end else begin
                    w_pcnt_nxt = r_pcnt + PcW'(1);
                end
            end

            // The ack is tested before the timeout, so an ack wins a tie.
            S_WAIT_ACK: begin
                if (r_timer != '1) begin
                    w_timer_nxt = r_timer + TimeoutW'(1);
                end
                if (w_sel_ack) begin
                    w_idx_nxt   = r_idx + IdxW'(1);
                    w_state_nxt = S_SELECT;
                end else if (w_timeout_hit) begin
                    w_error_nxt    = 1'b1;
                    w_err_core_nxt = r_idx[ErrW-1:0];
                    w_state_nxt    = S_ERROR;
                end
            end

            S_DONE:  w_state_nxt = S_IDLE;
            S_ERROR: w_state_nxt = S_IDLE;

            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs decode the registered state. Reset therefore drops exit_loop_o
    // asynchronously and suppresses done_o.
    always_comb begin
        exit_loop_o = '0;
        for (int i = 0; i < int'(NCores); i++) begin
            exit_loop_o[i] = (r_state == S_PULSE) && (r_idx == IdxW'(i));
        end
    end

    assign busy_o     = (r_state != S_IDLE);
    assign done_o     = (r_state == S_DONE) || (r_state == S_ERROR);
    assign error_o    = r_error;
    assign err_core_o = r_err_core;

endmodule
